// File: rtl/calc_isa_pkg.sv
// Shared ISA definitions for the calculator fetch/execute loop: field
// positions, opcodes, PC mode codes, sequencer states and field helpers.
package calc_isa_pkg;

    localparam int ISA_IW      = 16;
    localparam int ISA_AW      = 8;
    localparam int ISA_TIMEOUT = 15;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int ALUOP_HI = 9;
    localparam int ALUOP_LO = 8;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_BACK = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_JALU = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] PCM_INC  = 2'b00;
    localparam logic [1:0] PCM_DEC  = 2'b01;
    localparam logic [1:0] PCM_LOAD = 2'b10;
    localparam logic [1:0] PCM_ALU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_IMM,
        ACC_ALU
    } acc_sel_t;

    function automatic logic [3:0] get_opcode(input logic [ISA_IW-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [1:0] get_alu_op(input logic [ISA_IW-1:0] word);
        return word[ALUOP_HI:ALUOP_LO];
    endfunction

    function automatic logic [7:0] get_imm(input logic [ISA_IW-1:0] word);
        return word[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/calc_instr_decode.sv
// Combinational instruction decoder: turns the opcode, immediate and the
// accumulator-zero flag into PC mode, jump target, ALU controls and the
// accumulator load source, and flags HALT and illegal opcodes.
module calc_instr_decode
    import calc_isa_pkg::*;
#(
    parameter int AW = ISA_AW
)(
    input  logic [3:0]    i_opcode,
    input  logic [1:0]    i_alu_field,
    input  logic [AW-1:0] i_imm,
    input  logic          i_acc_zero,
    output logic [1:0]    o_m,
    output logic [AW-1:0] o_data_input,
    output logic [1:0]    o_alu_op,
    output logic [AW-1:0] o_alu_b,
    output acc_sel_t      o_acc_load_sel,
    output logic          o_is_halt,
    output logic          o_is_illegal
);

    // Opcode table; anything not listed is treated as illegal.
    always_comb begin
        o_m            = PCM_INC;
        o_data_input   = '0;
        o_alu_op       = 2'b00;
        o_alu_b        = '0;
        o_acc_load_sel = ACC_HOLD;
        o_is_halt      = 1'b0;
        o_is_illegal   = 1'b0;
        case (i_opcode)
            OP_NOP: begin
                o_m = PCM_INC;
            end
            OP_BACK: begin
                o_m = PCM_DEC;
            end
            OP_JMP: begin
                o_m          = PCM_LOAD;
                o_data_input = i_imm;
            end
            OP_JALU: begin
                o_m            = PCM_ALU;
                o_alu_op       = i_alu_field;
                o_alu_b        = i_imm;
                o_acc_load_sel = ACC_ALU;
            end
            OP_LDI: begin
                o_m            = PCM_INC;
                o_acc_load_sel = ACC_IMM;
            end
            OP_JZ: begin
                if (i_acc_zero) begin
                    o_m          = PCM_LOAD;
                    o_data_input = i_imm;
                end else begin
                    o_m = PCM_INC;
                end
            end
            OP_HALT: begin
                o_is_halt = 1'b1;
            end
            default: begin
                o_is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/calc_fetch_sequencer.sv
// Fetch/execute sequencer: fetches an instruction at the current PC over a
// req/ack handshake, decodes it into PC controls, strobes the PC block and
// steps the accumulator through the external ALU.
module calc_fetch_sequencer
    import calc_isa_pkg::*;
#(
    parameter int IW      = ISA_IW,
    parameter int AW      = ISA_AW,
    parameter int TIMEOUT = ISA_TIMEOUT
)(
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_run,
    input  logic [AW-1:0] i_pc,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [IW-1:0] i_mem_rdata,
    output logic [1:0]    o_m,
    output logic [AW-1:0] o_data_input,
    output logic          o_pc_step,
    output logic [1:0]    o_alu_op,
    output logic [AW-1:0] o_alu_a,
    output logic [AW-1:0] o_alu_b,
    input  logic [AW-1:0] i_res_alu,
    output logic          o_halted,
    output logic          o_fault
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    seq_state_t     r_state;
    seq_state_t     w_next_state;
    logic           w_set_halt;
    logic           w_set_fault;

    logic [IW-1:0]    r_instr;
    logic [AW-1:0]    r_acc;
    logic [TMO_W-1:0] r_tmo_cnt;
    acc_sel_t         r_acc_sel;

    logic             r_mem_req;
    logic [AW-1:0]    r_mem_addr;
    logic [1:0]       r_m;
    logic [AW-1:0]    r_data_input;
    logic [1:0]       r_alu_op;
    logic [AW-1:0]    r_alu_b;
    logic             r_pc_step;
    logic             r_halted;
    logic             r_fault;

    logic [1:0]       w_dec_m;
    logic [AW-1:0]    w_dec_data_input;
    logic [1:0]       w_dec_alu_op;
    logic [AW-1:0]    w_dec_alu_b;
    acc_sel_t         w_dec_acc_sel;
    logic             w_dec_is_halt;
    logic             w_dec_is_illegal;
    logic             w_acc_zero;
    logic             w_tmo_expired;
    logic             w_unused_bits;

    assign w_acc_zero    = (r_acc == '0);
    assign w_tmo_expired = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign w_unused_bits = ^r_instr[11:10];

    calc_instr_decode #(
        .AW (AW)
    ) u_decode (
        .i_opcode       (get_opcode(r_instr)),
        .i_alu_field    (get_alu_op(r_instr)),
        .i_imm          (get_imm(r_instr)),
        .i_acc_zero     (w_acc_zero),
        .o_m            (w_dec_m),
        .o_data_input   (w_dec_data_input),
        .o_alu_op       (w_dec_alu_op),
        .o_alu_b        (w_dec_alu_b),
        .o_acc_load_sel (w_dec_acc_sel),
        .o_is_halt      (w_dec_is_halt),
        .o_is_illegal   (w_dec_is_illegal)
    );

    // State register; clr returns to IDLE from anywhere, including HALT.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the halt/fault set requests.
    always_comb begin
        w_next_state = r_state;
        w_set_halt   = 1'b0;
        w_set_fault  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_mem_ack) begin
                    w_next_state = ST_DECODE;
                end else if (w_tmo_expired) begin
                    w_next_state = ST_HALT;
                    w_set_halt   = 1'b1;
                    w_set_fault  = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_dec_is_halt) begin
                    w_next_state = ST_HALT;
                    w_set_halt   = 1'b1;
                end else if (w_dec_is_illegal) begin
                    w_next_state = ST_HALT;
                    w_set_halt   = 1'b1;
                    w_set_fault  = 1'b1;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = i_run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Fetch side: request, address capture on FETCH entry, timeout count, instruction latch.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_tmo_cnt  <= '0;
            r_instr    <= '0;
        end else begin
            r_mem_req <= (w_next_state == ST_FETCH);
            if (r_state != ST_FETCH && w_next_state == ST_FETCH) begin
                r_mem_addr <= i_pc;
                r_tmo_cnt  <= '0;
            end else if (r_state == ST_FETCH) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (r_state == ST_FETCH && i_mem_ack) begin
                r_instr <= i_mem_rdata;
            end
        end
    end

    // Decode side: PC and ALU controls are captured once and held until the next decode.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_m          <= PCM_INC;
            r_data_input <= '0;
            r_alu_op     <= 2'b00;
            r_alu_b      <= '0;
            r_acc_sel    <= ACC_HOLD;
        end else if (r_state == ST_DECODE && !w_dec_is_halt && !w_dec_is_illegal) begin
            r_m          <= w_dec_m;
            r_data_input <= w_dec_data_input;
            r_alu_op     <= w_dec_alu_op;
            r_alu_b      <= w_dec_alu_b;
            r_acc_sel    <= w_dec_acc_sel;
        end
    end

    // Execute side: step strobe covers exactly the EXEC cycle, accumulator commits at its end.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_pc_step <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_pc_step <= (w_next_state == ST_EXEC);
            if (r_state == ST_EXEC) begin
                case (r_acc_sel)
                    ACC_IMM:  r_acc <= get_imm(r_instr);
                    ACC_ALU:  r_acc <= i_res_alu;
                    default:  r_acc <= r_acc;
                endcase
            end
        end
    end

    // Sticky status flags, cleared only by clr.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_m          = r_m;
    assign o_data_input = r_data_input;
    assign o_pc_step    = r_pc_step;
    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_acc;
    assign o_alu_b      = r_alu_b;
    assign o_halted     = r_halted;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_calc_fetch_sequencer.sv
// Testbench for calc_fetch_sequencer: surrounds the sequencer with a program
// memory, PC block and ALU, and checks it against an instruction-level model
// through an expectation queue.
module tb_calc_fetch_sequencer;

    localparam int TIMEOUT = 15;

    typedef struct {
        bit         isHalt;
        bit         expFault;
        int         dueCycle;
        logic [1:0] m;
        logic [7:0] di;
        logic [1:0] aluOp;
        logic [7:0] aluB;
        logic [7:0] accBefore;
    } expItem_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [7:0]  pc;
    logic        memReq;
    logic [7:0]  memAddr;
    logic        memAck;
    logic [15:0] memRdata;
    logic [1:0]  m;
    logic [7:0]  dataInput;
    logic        pcStep;
    logic [1:0]  aluOp;
    logic [7:0]  aluA;
    logic [7:0]  aluB;
    logic [7:0]  resAlu;
    logic        halted;
    logic        fault;

    logic [15:0] progMem [256];
    expItem_t    expQ [$];
    expItem_t    monItem;
    int          checks = 0;
    int          passes = 0;
    int          cycleCount = 0;
    int          stepCount = 0;
    int          waitLeft = -1;
    bit          memEnable = 1'b0;
    bit          fixedLat = 1'b1;
    bit          spuriousEn = 1'b0;
    bit          prevHalted = 1'b0;
    logic [7:0]  mPc = 8'h00;
    logic [7:0]  mAcc = 8'h00;

    calc_fetch_sequencer dut (
        .i_clk        (clk),
        .i_clr        (clr),
        .i_run        (run),
        .i_pc         (pc),
        .o_mem_req    (memReq),
        .o_mem_addr   (memAddr),
        .i_mem_ack    (memAck),
        .i_mem_rdata  (memRdata),
        .o_m          (m),
        .o_data_input (dataInput),
        .o_pc_step    (pcStep),
        .o_alu_op     (aluOp),
        .o_alu_a      (aluA),
        .o_alu_b      (aluB),
        .i_res_alu    (resAlu),
        .o_halted     (halted),
        .o_fault      (fault)
    );

    always #5 clk = ~clk;

    // Calculator ALU seen by the sequencer: 00 sub, 01 add, 10 and, 11 xor.
    function automatic logic [7:0] aluRef(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a - b;
            2'b01:   return a + b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign resAlu = aluRef(aluOp, aluA, aluB);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Instruction-level model: executes the fetched word and queues what the sequencer must show.
    task automatic modelIssue(input logic [15:0] word);
        expItem_t   it;
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] res;
        op  = word[15:12];
        imm = word[7:0];
        checkOutput("fetchAddr", memAddr, mPc);
        it.isHalt    = 1'b0;
        it.expFault  = 1'b0;
        it.dueCycle  = cycleCount + 2;
        it.m         = 2'b00;
        it.di        = 8'h00;
        it.aluOp     = word[9:8];
        it.aluB      = imm;
        it.accBefore = mAcc;
        case (op)
            4'h0: begin it.m = 2'b00; mPc = mPc + 8'd1; end
            4'h1: begin it.m = 2'b01; mPc = mPc - 8'd1; end
            4'h2: begin it.m = 2'b10; it.di = imm; mPc = imm; end
            4'h3: begin
                it.m = 2'b11;
                res  = aluRef(word[9:8], mAcc, imm);
                mPc  = res;
                mAcc = res;
            end
            4'h4: begin it.m = 2'b00; mPc = mPc + 8'd1; mAcc = imm; end
            4'h5: begin
                if (mAcc == 8'h00) begin
                    it.m = 2'b10; it.di = imm; mPc = imm;
                end else begin
                    it.m = 2'b00; mPc = mPc + 8'd1;
                end
            end
            4'hF: begin it.isHalt = 1'b1; end
            default: begin it.isHalt = 1'b1; it.expFault = 1'b1; end
        endcase
        expQ.push_back(it);
    endtask

    // Cycle counter used to time expectations.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // PC block: commits on the negedge inside the step cycle.
    always @(negedge clk) begin
        if (clr) begin
            pc = 8'h00;
        end else if (pcStep) begin
            case (m)
                2'b00:   pc = pc + 8'd1;
                2'b01:   pc = pc - 8'd1;
                2'b10:   pc = dataInput;
                default: pc = resAlu;
            endcase
        end
    end

    // Program memory: answers requests after 0..3 cycles, sometimes pulses ack while idle.
    always @(negedge clk) begin
        memAck   = 1'b0;
        memRdata = 16'($urandom);
        if (memReq && memEnable) begin
            if (waitLeft < 0) begin
                waitLeft = fixedLat ? 0 : int'($urandom_range(0, 3));
            end
            if (waitLeft == 0) begin
                memAck   = 1'b1;
                memRdata = progMem[memAddr];
                modelIssue(memRdata);
                waitLeft = -1;
            end else begin
                waitLeft--;
            end
        end else if (!memReq) begin
            waitLeft = -1;
            if (spuriousEn && $urandom_range(0, 7) == 0) begin
                memAck = 1'b1;
            end
        end
    end

    // Monitor: pops an expectation whenever a step or a halt appears.
    always @(negedge clk) begin
        if (pcStep) begin
            stepCount++;
            if (expQ.size() == 0) begin
                checkOutput("stepUnexpected", pcStep, 1'b0);
            end else if (expQ[0].isHalt) begin
                checkOutput("stepInsteadOfHalt", pcStep, 1'b0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("stepCycle", cycleCount, monItem.dueCycle);
                checkOutput("stepM", m, monItem.m);
                if (monItem.m == 2'b10) checkOutput("stepDataInput", dataInput, monItem.di);
                if (monItem.m == 2'b11) begin
                    checkOutput("stepAluOp", aluOp, monItem.aluOp);
                    checkOutput("stepAluB", aluB, monItem.aluB);
                end
                checkOutput("stepAluA", aluA, monItem.accBefore);
            end
        end
        if (halted && !prevHalted) begin
            if (expQ.size() == 0 || !expQ[0].isHalt) begin
                checkOutput("haltUnexpected", halted, 1'b0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("haltCycle", cycleCount, monItem.dueCycle);
                checkOutput("haltFault", fault, monItem.expFault);
            end
        end
        prevHalted = halted;
    end

    task automatic applyStimulus(input bit clrVal, input bit runVal, input int cycles);
        clr = clrVal;
        run = runVal;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic resetDut();
        memEnable  = 1'b0;
        spuriousEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 2);
        mPc  = 8'h00;
        mAcc = 8'h00;
        expQ.delete();
        for (int i = 0; i < 256; i++) progMem[i] = 16'h0000;
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_memReq"}, memReq, 1'b0);
        checkOutput({tag, "_memAddr"}, memAddr, 8'h00);
        checkOutput({tag, "_m"}, m, 2'b00);
        checkOutput({tag, "_dataInput"}, dataInput, 8'h00);
        checkOutput({tag, "_pcStep"}, pcStep, 1'b0);
        checkOutput({tag, "_aluOp"}, aluOp, 2'b00);
        checkOutput({tag, "_aluA"}, aluA, 8'h00);
        checkOutput({tag, "_aluB"}, aluB, 8'h00);
        checkOutput({tag, "_halted"}, halted, 1'b0);
        checkOutput({tag, "_fault"}, fault, 1'b0);
    endtask

    task automatic waitHalted(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, halted, 1'b1);
    endtask

    task automatic waitReq(input int budget, input string name);
        int n = 0;
        while (!memReq && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, memReq, 1'b1);
    endtask

    task automatic waitSteps(input int target, input int budget, input string name);
        int n = 0;
        while (stepCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (stepCount >= target), 1'b1);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int reqCycles;
        int quiet;
        int n;
        expItem_t tmo;

        clr = 1'b1;
        run = 1'b0;
        @(negedge clk);
        resetDut();
        checkAllZero("reset");

        // NOP at 00, JMP 42, then HALT; halt must be absorbing with run held high.
        progMem[8'h00] = 16'h0000;
        progMem[8'h01] = 16'h2042;
        progMem[8'h42] = 16'hF000;
        base = stepCount;
        memEnable = 1'b1;
        fixedLat  = 1'b1;
        applyStimulus(1'b0, 1'b1, 1);
        waitHalted(60, "haltReached");
        checkOutput("haltSteps", stepCount - base, 2);
        checkOutput("haltNoFault", fault, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("haltNoReq", memReq, 1'b0);
        end
        checkOutput("haltNoMoreSteps", stepCount - base, 2);

        // JMP 80, LDI FF, JALU add 01 -> wraps to 00, JZ 10 taken, then an illegal opcode.
        resetDut();
        progMem[8'h00] = 16'h2080;
        progMem[8'h80] = 16'h40FF;
        progMem[8'h81] = 16'h3101;
        progMem[8'h10] = 16'h7000;
        base = stepCount;
        memEnable = 1'b1;
        applyStimulus(1'b0, 1'b1, 1);
        waitSteps(base + 1, 30, "firstJmpStep");
        progMem[8'h00] = 16'h5010;
        waitHalted(80, "illegalHalt");
        checkOutput("illegalFault", fault, 1'b1);
        checkOutput("wrapAcc", aluA, 8'h00);
        checkOutput("illegalSteps", stepCount - base, 4);

        // Memory never answers: timeout after TIMEOUT request cycles.
        resetDut();
        base = stepCount;
        applyStimulus(1'b0, 1'b1, 0);
        waitReq(10, "tmoReqSeen");
        tmo.isHalt    = 1'b1;
        tmo.expFault  = 1'b1;
        tmo.dueCycle  = cycleCount + TIMEOUT;
        tmo.m         = 2'b00;
        tmo.di        = 8'h00;
        tmo.aluOp     = 2'b00;
        tmo.aluB      = 8'h00;
        tmo.accBefore = 8'h00;
        expQ.push_back(tmo);
        reqCycles = 1;
        n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
            if (memReq) reqCycles++;
        end
        checkOutput("tmoReqCycles", reqCycles, TIMEOUT);
        checkOutput("tmoFault", fault, 1'b1);
        checkOutput("tmoHalted", halted, 1'b1);
        checkOutput("tmoReqLow", memReq, 1'b0);
        checkOutput("tmoNoStep", stepCount - base, 0);

        // clr in the middle of a handshake.
        resetDut();
        applyStimulus(1'b0, 1'b1, 0);
        waitReq(10, "clrReqSeen");
        applyStimulus(1'b1, 1'b1, 1);
        checkAllZero("clrMid");
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("clrHeldReq", memReq, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("clrIdleReq", memReq, 1'b0);
        end
        mPc  = 8'h00;
        mAcc = 8'h00;
        expQ.delete();
        base = stepCount;
        memEnable = 1'b1;
        applyStimulus(1'b0, 1'b1, 0);
        waitSteps(base + 1, 20, "clrFreshFetch");

        // Randomized programs with random latency, run toggling and stray acks.
        run = 1'b0;
        resetDut();
        for (int i = 0; i < 256; i++) begin
            progMem[i] = {4'($urandom_range(0, 5)), 12'($urandom)};
        end
        base = stepCount;
        memEnable  = 1'b1;
        fixedLat   = 1'b0;
        spuriousEn = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            run = ($urandom_range(0, 9) != 0);
            @(negedge clk);
        end
        run = 1'b0;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (!memReq && !pcStep && expQ.size() == 0) quiet++;
            else quiet = 0;
        end
        checkOutput("randomDrained", quiet, 4);
        checkOutput("randomProgress", (stepCount - base > 100), 1'b1);
        checkOutput("randomNoHalt", halted, 1'b0);
        checkOutput("randomNoFault", fault, 1'b0);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
